// File: rtl/inv_shift_rows.sv
// rtl/inv_shift_rows.sv - streaming AES InvShiftRows stage with output FIFO (optional SHIFT_ROWS_DIR_SEL_EN adds forward/inverse select)
module inv_shift_rows #(
    parameter int word_size  = 8,
    parameter int array_size = 16,
    parameter int depth      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
`ifdef SHIFT_ROWS_DIR_SEL_EN
    input  logic                                inv,
`endif
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [0:word_size*array_size-1]     Data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [0:word_size*array_size-1]     Shifted_Data,
    output logic                                done,
    output logic [$clog2(depth+1)-1:0]          count
);

    localparam int DW = word_size * array_size;
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    // Byte permutation of the 4x4 column-major state. inverse=1 rotates each
    // row r right by r positions, inverse=0 rotates it left (forward ShiftRows).
    function automatic logic [0:DW-1] shift_rows(input logic [0:DW-1] d, input logic inverse);
        logic [0:DW-1] o;
        int src_c;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src_c = inverse ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[(4*c+r)*word_size +: word_size] = d[(4*src_c+r)*word_size +: word_size];
            end
        end
        return o;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [0:DW-1] mem [depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          mode;
    logic          push;
    logic          pop;
    logic [0:DW-1] xformed;

`ifdef SHIFT_ROWS_DIR_SEL_EN
    assign mode = inv;
`else
    assign mode = 1'b1;
`endif

    // Transform on the way in so each entry already carries its own direction;
    // a later mode change cannot touch blocks that are queued.
    assign xformed      = shift_rows(Data, mode);

    assign in_ready     = !rst && (count < CW'(depth));
    assign out_valid    = (count != '0);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign Shifted_Data = mem[rd_ptr];

    // FIFO storage, pointers, occupancy and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            done   <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= xformed;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            done <= pop;
        end
    end

endmodule

// File: doc/inv_shift_rows.md
# inv_shift_rows

Streaming AES InvShiftRows stage for the decryption datapath. It accepts one 128-bit state per valid/ready handshake and cyclically right-shifts row r of the 4x4 byte matrix by r positions. The result is held in a small output FIFO so that back-pressure from the downstream InvSubBytes stage never drops a block. It sits between AddRoundKey/InvMixColumns and InvSubBytes in the inverse round.

## Interface
- word_size, 8, bits per state byte
- array_size, 16, bytes per state (word_size*array_size = 128)
- depth, 2, output FIFO entries (power of two, >= 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  Data is valid this cycle
- in_ready  output  1  block can accept Data this cycle
- Data  input  [0:word_size*array_size-1]  input state; byte k = Data[k*word_size +: word_size], k = 4*col+row (column-major, byte 0 at bit 0)
- out_valid  output  1  Shifted_Data holds a valid state
- out_ready  input  1  downstream accepts Shifted_Data this cycle
- Shifted_Data  output  [0:word_size*array_size-1]  transformed state, same byte ordering
- done  output  1  one-cycle pulse the cycle a block leaves the FIFO (out_valid & out_ready)
- count  output  $clog2(depth+1)  FIFO occupancy

## Operation
- Transform: out byte (4c+r) = in byte (4*((c-r) mod 4)+r), for r,c in 0..3. Row 0 is unchanged. Pure byte permutation, no arithmetic.
- Accept: a block is accepted when in_valid & in_ready. Its transformed value is written into the FIFO tail that edge.
- in_ready = (count < depth). It is combinational from registered state only, never from in_valid or out_ready.
- Output: out_valid = (count != 0). Shifted_Data = FIFO head (registered storage, no combinational path from Data).
- Pop: a block is popped on out_valid & out_ready. done is registered and asserts the cycle after the pop edge.
- Simultaneous push and pop:
  - When full, count < depth is false, so in_ready=0 and no push occurs; a same-cycle pop does not enable a push.
  - When non-full and non-empty, push and pop both occur and count is unchanged.
  - When empty, no pop is possible, so count becomes 1.
- Pointers: read/write pointers wrap modulo depth.
- Holding: Shifted_Data and out_valid hold stable while out_valid & !out_ready (AXI-style). Data is ignored when in_valid=0.

## Timing
- Latency: 1 cycle. A block accepted on edge N is visible with out_valid=1 after edge N if the FIFO was empty.
- Throughput: 1 block/cycle when out_ready is held high.
- Reset values: in_ready=0 during rst, 1 the cycle after release; out_valid=0; Shifted_Data=0; done=0; count=0; pointers=0.
- Reset mid-operation discards all FIFO contents, and no done pulse is produced for discarded blocks.

## Configuration
- SHIFT_ROWS_DIR_SEL_EN defined:
  - Adds input port `inv` (1 bit), sampled together with Data on accept.
  - inv=1 selects InvShiftRows as above.
  - inv=0 selects forward ShiftRows: out byte (4c+r) = in byte (4*((c+r) mod 4)+r).
  - The selection is stored per FIFO entry, so a mode change never affects blocks already accepted.
- SHIFT_ROWS_DIR_SEL_EN undefined: no `inv` port; the block is inverse-only.

## Test plan
- Identity vector: Data=000102030405060708090a0b0c0d0e0f, out_ready=1 -> after 1 cycle Shifted_Data=000d0a0704010e0b0805020f0c090603, out_valid=1, done pulses the next cycle.
- Back-pressure: out_ready=0, push 3 blocks back-to-back -> in_ready drops after the 2nd block (count=2); the 3rd block is held by the source. Raise out_ready -> blocks emerge in order, intact.
- Streaming: out_ready=1, push 8 random blocks on consecutive cycles -> 8 outputs on consecutive cycles, each matching the reference permutation; count stays <= 1.
- Reset mid-stream: with count=2, assert rst for 1 cycle -> out_valid=0, count=0, Shifted_Data=0, no done; the next block after release passes normally.
- Round trip (with SHIFT_ROWS_DIR_SEL_EN): push 000102...0f with inv=0 -> 00050a0f04090e03080d02070c01060b. Feed that back with inv=1 -> 000102030405060708090a0b0c0d0e0f.
- Output stability: hold out_ready=0 for 5 cycles with out_valid=1 -> Shifted_Data unchanged every cycle while the source keeps toggling Data.
